// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub: operands and start in, status and result out.
// start is a single-cycle request, taken only when the unit is idle or presenting done.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic [1:0]       fsm_state;

  modport master (
    output start, mode, a, b, c,
    input  busy, done, result, cout, ovf, fsm_state
  );

  modport slave (
    input  start, mode, a, b, c,
    output busy, done, result, cout, ovf, fsm_state
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: BITS_PER_CYCLE bits per clock, LSB chunk first, through a
// chained full-adder slice; result/cout/ovf presented on a one-cycle done strobe.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                cy;
  logic                mode_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    result_q;
  logic                cout_q;
  logic                ovf_q;

  logic [BITS_PER_CYCLE-1:0] ac;
  logic [BITS_PER_CYCLE-1:0] bc;
  logic [BITS_PER_CYCLE-1:0] sum;
  logic                      chain;
  logic                      c_msb;
  logic                      last;

  assign ac   = a_q[BITS_PER_CYCLE-1:0];
  assign bc   = b_q[BITS_PER_CYCLE-1:0];
  assign last = (cnt == CW'(N - 1));

  // c_msb ends as the carry into the top bit of the chunk; on the final chunk that is the MSB.
  always_comb begin
    chain = cy;
    c_msb = cy;
    sum   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      c_msb  = chain;
      sum[i] = ac[i] ^ bc[i] ^ chain;
      chain  = (ac[i] & bc[i]) | (chain & (ac[i] ^ bc[i]));
    end
  end

  // Operands shift down one chunk per cycle and result fills from the top, so after N
  // chunks every bit sits at its own position without indexed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy       <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            a_q    <= bus.a;
            b_q    <= bus.mode ? ~bus.b : bus.b;
            cy     <= bus.mode ? ~bus.c : bus.c;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result_q <= WIDTH'({sum, result_q} >> BITS_PER_CYCLE);
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          cy       <= chain;
          cnt      <= cnt + CW'(1);
          if (last) begin
            cout_q <= mode_q ? ~chain : chain;
            ovf_q  <= c_msb ^ chain;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.fsm_state = state;
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit and the sequential successor to the team's single-bit full-adder/full-subtractor cells.
- Latches two WIDTH-bit operands on a start pulse, then processes BITS_PER_CYCLE bits per clock, LSB chunk first, through a chained full-adder slice.
- Reports the result with carry/borrow and signed overflow on a one-cycle done strobe.
- Used wherever area matters more than latency: small datapaths, checksum and accumulate paths.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE or DONE
mode  input  1  0 = add (a+b+c), 1 = subtract (a-b-c); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
c  input  1  carry-in (add) or borrow-in (sub); sampled with start
busy  output  1  high while chunks are being computed
done  output  1  one-cycle strobe; result, cout and ovf are valid
result  output  WIDTH  sum or difference, modulo 2^WIDTH
cout  output  1  carry-out (add) or borrow-out (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: rst_n low immediately forces state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, chunk counter=0 and latched operands=0.
  - Applies at any point, including mid-RUN. The aborted operation is discarded and no done is produced for it.
- N = WIDTH/BITS_PER_CYCLE.
- FSM states:
  - IDLE: start=1 latches mode/a/b/c, clears counter, goes to RUN.
  - RUN: each edge computes one chunk, writes it into result[chunk], propagates the internal carry, and increments the counter. After the Nth chunk, goes to DONE.
  - DONE: done=1 for exactly this one cycle. start=1 here is accepted (back-to-back, goes to RUN); otherwise goes to IDLE.
- Latency: start accepted at edge k gives busy=1 after edges k..k+N-1 (N cycles) and done=1 in the cycle after edge k+N. No idle bubble is required between operations.
- start while busy=1 is ignored, with no effect on the operation in flight. Input changes during RUN are ignored because operands are latched.
- Arithmetic: subtraction is implemented as a + ~b + ~c.
  - Internal carry-in = c for add, ~c for sub.
  - Add: cout = final carry.
  - Sub: cout = ~final carry, so borrow=1 iff a < b + c, unsigned.
- ovf = carry into MSB XOR carry out of MSB, computed in the internal-add form for both modes.
- result/cout/ovf are valid only when done=1, and are held unchanged until the next accepted start.
  - result bits may change chunk by chunk during RUN.
  - cout and ovf update only on the final chunk.
- BITS_PER_CYCLE=WIDTH degenerates to N=1: busy for one cycle, then done.

Test Plan:
1. WIDTH=8, BPC=1; mode=0, a=0x5A, b=0x33, c=0 -> busy high exactly 8 cycles, then done one cycle; result=0x8D, cout=0, ovf=1.
2. mode=1, a=0x10, b=0x20, c=0 -> result=0xF0, cout=1 (borrow), ovf=0. Then mode=1, a=0x80, b=0x01, c=0 -> result=0x7F, cout=0, ovf=1.
3. mode=0, a=0xFF, b=0x00, c=1 -> result=0x00, cout=1, ovf=0. Then mode=1, a=0x05, b=0x05, c=1 -> result=0xFF, cout=1, ovf=0.
4. start pulsed again mid-RUN with other operands -> ignored; original result delivered. start held high through the DONE cycle with a=0x01, b=0x01, mode=0 -> second op starts without a bubble; result=0x02 after 8 more busy cycles.
5. rst_n driven low asynchronously at chunk 4 of a run -> all outputs 0 immediately, no done. After release, a=0x7F+0x01 -> result=0x80, ovf=1.
6. WIDTH=8, BPC=4 and WIDTH=4, BPC=4: check busy = 2 and 1 cycles respectively. Exhaustive a/b/c/mode at WIDTH=4 against a reference model -> all result/cout/ovf match.
